run_controller: RTL
===================

Name: run_controller

Overview:
- Synthesisable run-control and result-capture block for the single-cycle datapath.
- On start it zeroes data memory and register file through their write ports, then releases the core from reset.
- It watches the PC for a halt (jump-to-self) or a cycle timeout, then freezes the core and reads two result registers, e.g. n and fib(n).
- It generalises the fixed-delay bench flow: depths, widths, result registers and timeout are parameters.

Parameters:
- DATA_W, 32, data/register word width
- DMEM_DEPTH, 32, data memory words to clear
- RF_DEPTH, 32, register file entries to clear
- ADDR_W, 5, clear/read address width; must satisfy 2^ADDR_W >= max(DMEM_DEPTH, RF_DEPTH)
- PC_W, 32, program counter width
- MAX_CYCLES, 90, RUN cycles before timeout
- STABLE_CYCLES, 3, consecutive unchanged-PC cycles that mean halt
- RES_REG_A, 16, first result register index
- RES_REG_B, 17, second result register index

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  begin clear+run; sampled only in IDLE/DONE
- dmem_we  out  1  data memory write enable (clear)
- dmem_addr  out  ADDR_W  data memory clear address
- rf_we  out  1  register file write enable (clear)
- rf_waddr  out  ADDR_W  register file clear address
- clr_wdata  out  DATA_W  write data; constant 0
- core_rst  out  1  held-in-reset control to datapath
- pc  in  PC_W  core program counter
- rf_raddr  out  ADDR_W  register file read address (combinational read)
- rf_rdata  in  DATA_W  register file read data
- result_a  out  DATA_W  captured RES_REG_A value
- result_b  out  DATA_W  captured RES_REG_B value
- cycles  out  32  RUN cycles elapsed
- timeout  out  1  run ended by MAX_CYCLES
- done  out  1  results valid

Behaviour:
- States: IDLE, CLEAR, RUN, READ_A, READ_B, DONE.
- Reset (async, any state, mid-operation included): state IDLE; core_rst=1; all other outputs 0; counters, pc_prev and stable_cnt cleared.
- IDLE: core_rst=1. start=1 -> CLEAR next edge, with clear index k=0.
- CLEAR, N = max(DMEM_DEPTH, RF_DEPTH) cycles, k = 0..N-1:
  - dmem_we = (k < DMEM_DEPTH); dmem_addr = k.
  - rf_we = (k < RF_DEPTH); rf_waddr = k.
  - clr_wdata=0; core_rst=1.
  - After k=N-1 -> RUN.
  - Entering CLEAR clears cycles, timeout, done, result_a and result_b.
- RUN: core_rst=0; dmem_we=rf_we=0.
  - cycles increments each RUN cycle and saturates at 2^32-1.
  - First RUN cycle: pc_prev<=pc, stable_cnt<=0, no comparison.
  - Later cycles: pc==pc_prev -> stable_cnt+1; otherwise stable_cnt<=0. pc_prev<=pc every cycle.
  - Halt: stable_cnt reaches STABLE_CYCLES -> READ_A, timeout=0.
  - Timeout: cycles reaches MAX_CYCLES without halt -> READ_A, timeout=1.
  - Halt and timeout on the same cycle: halt wins, timeout=0.
- READ_A: core_rst=1 (freeze core); rf_raddr=RES_REG_A; result_a<=rf_rdata at the edge -> READ_B.
- READ_B: rf_raddr=RES_REG_B; result_b<=rf_rdata at the edge -> DONE.
- DONE: done=1; core_rst=1; results, cycles and timeout held. start=1 -> CLEAR, with done dropping to 0 that edge.
- start is ignored in CLEAR, RUN, READ_A and READ_B.
- rf_raddr is 0 outside the READ states.
- Latency from start (IDLE) to done: 1 + N + R + 2 edges, where R = RUN cycles.

Test Plan:
- Reset mid-CLEAR at k=10 -> IDLE next edge asynchronously, core_rst=1, dmem_we=0; restarting start repeats the full clear from k=0.
- start with defaults -> exactly 32 cycles of dmem_we=rf_we=1, addresses 0..31, wdata 0, then core_rst falls.
- DMEM_DEPTH=16, RF_DEPTH=32 -> dmem_we high for k=0..15 only; rf_we high for k=0..31; CLEAR lasts 32 cycles.
- Core model computes fibonacci, writing r16=10, r17=55, then pc sticks at 0x40 -> halt after 3 stable cycles; result_a=10, result_b=55, timeout=0, done=1.
- pc increments forever -> timeout=1, cycles=90, done=1, results hold whatever r16/r17 contain.
- pc stable on the same cycle cycles hits 90 -> timeout=0; then start in DONE -> done=0 next edge, new clear begins.

Source files
------------

// File: rtl/run_controller.sv
// run_controller
//   Run-control and result capture for the single-cycle datapath. On start
//   it walks a clear index across data memory and register file (writing 0),
//   releases the core, watches the PC for a jump-to-self halt or a cycle
//   timeout, then freezes the core and reads two result registers.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   start                 begin clear+run (honoured in IDLE/DONE only)
//   dmem_we, dmem_addr    data memory clear port
//   rf_we, rf_waddr       register file clear port
//   clr_wdata             clear write data (always 0)
//   core_rst              holds the datapath in reset when 1
//   pc                    core program counter
//   rf_raddr, rf_rdata    register file combinational read port
//   result_a, result_b    captured result registers
//   cycles                RUN cycles elapsed (saturating)
//   timeout               run ended by the cycle limit
//   done                  results valid
module run_controller #(
  parameter int DATA_W        = 32,
  parameter int DMEM_DEPTH    = 32,
  parameter int RF_DEPTH      = 32,
  parameter int ADDR_W        = 5,
  parameter int PC_W          = 32,
  parameter int MAX_CYCLES    = 90,
  parameter int STABLE_CYCLES = 3,
  parameter int RES_REG_A     = 16,
  parameter int RES_REG_B     = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] clr_wdata,
  output logic              core_rst,
  input  logic [PC_W-1:0]   pc,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] result_a,
  output logic [DATA_W-1:0] result_b,
  output logic [31:0]       cycles,
  output logic              timeout,
  output logic              done
);

  localparam int N    = (DMEM_DEPTH > RF_DEPTH) ? DMEM_DEPTH : RF_DEPTH;
  localparam int SC_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [ADDR_W-1:0] K_LAST     = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   DMEM_LIM   = (ADDR_W + 1)'(DMEM_DEPTH);
  localparam logic [ADDR_W:0]   RF_LIM     = (ADDR_W + 1)'(RF_DEPTH);
  localparam logic [31:0]       MAX_C      = 32'(MAX_CYCLES);
  localparam logic [SC_W-1:0]   STABLE_LIM = SC_W'(STABLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_READ_A, S_READ_B, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  k_q, k_d;
  logic [31:0]        cycles_q, cycles_d;
  logic [SC_W-1:0]    stable_cnt_q, stable_cnt_d;
  logic [PC_W-1:0]    pc_prev_q, pc_prev_d;
  logic               timeout_q, timeout_d;
  logic [DATA_W-1:0]  result_a_q, result_a_d;
  logic [DATA_W-1:0]  result_b_q, result_b_d;

  logic [31:0]        cycles_inc;
  logic [SC_W-1:0]    stable_next;
  logic               first_run;
  logic               halt;
  logic               time_up;

  // RUN-cycle bookkeeping. cycles is zeroed on entry to CLEAR, so a zero
  // count marks the first RUN cycle, where pc_prev is not yet meaningful.
  always_comb begin
    cycles_inc  = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;
    first_run   = (cycles_q == '0);
    stable_next = '0;
    if (!first_run && (pc == pc_prev_q)) begin
      stable_next = (stable_cnt_q == STABLE_LIM) ? stable_cnt_q
                                                 : stable_cnt_q + 1'b1;
    end
    halt    = (state_q == S_RUN) && (stable_next == STABLE_LIM) && !first_run;
    time_up = (state_q == S_RUN) && (cycles_inc >= MAX_C);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CLEAR;
      S_CLEAR:  if (k_q == K_LAST) state_d = S_RUN;
      S_RUN:    if (halt || time_up) state_d = S_READ_A;
      S_READ_A: state_d = S_READ_B;
      S_READ_B: state_d = S_DONE;
      S_DONE:   if (start) state_d = S_CLEAR;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q          <= '0;
      cycles_q     <= '0;
      stable_cnt_q <= '0;
      pc_prev_q    <= '0;
      timeout_q    <= 1'b0;
      result_a_q   <= '0;
      result_b_q   <= '0;
    end else begin
      k_q          <= k_d;
      cycles_q     <= cycles_d;
      stable_cnt_q <= stable_cnt_d;
      pc_prev_q    <= pc_prev_d;
      timeout_q    <= timeout_d;
      result_a_q   <= result_a_d;
      result_b_q   <= result_b_d;
    end
  end

  always_comb begin
    k_d          = k_q;
    cycles_d     = cycles_q;
    stable_cnt_d = stable_cnt_q;
    pc_prev_d    = pc_prev_q;
    timeout_d    = timeout_q;
    result_a_d   = result_a_q;
    result_b_d   = result_b_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          k_d          = '0;
          cycles_d     = '0;
          stable_cnt_d = '0;
          pc_prev_d    = '0;
          timeout_d    = 1'b0;
          result_a_d   = '0;
          result_b_d   = '0;
        end
      end
      S_CLEAR: k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
      S_RUN: begin
        cycles_d     = cycles_inc;
        stable_cnt_d = stable_next;
        pc_prev_d    = pc;
        // A halt seen on the limit cycle is still a clean halt.
        if (halt) begin
          timeout_d = 1'b0;
        end else if (time_up) begin
          timeout_d = 1'b1;
        end
      end
      S_READ_A: result_a_d = rf_rdata;
      S_READ_B: result_b_d = rf_rdata;
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    dmem_we   = 1'b0;
    dmem_addr = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_raddr  = '0;
    core_rst  = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_CLEAR: begin
        dmem_we   = ({1'b0, k_q} < DMEM_LIM);
        dmem_addr = k_q;
        rf_we     = ({1'b0, k_q} < RF_LIM);
        rf_waddr  = k_q;
      end
      S_RUN:    core_rst = 1'b0;
      S_READ_A: rf_raddr = ADDR_W'(RES_REG_A);
      S_READ_B: rf_raddr = ADDR_W'(RES_REG_B);
      S_DONE:   done = 1'b1;
      default: ;
    endcase
  end

  assign clr_wdata = '0;
  assign result_a  = result_a_q;
  assign result_b  = result_b_q;
  assign cycles    = cycles_q;
  assign timeout   = timeout_q;

endmodule
